moldudp64_msg_splitter: RTL and testbench

- Sits directly downstream of the Ethernet/IPv4/UDP header stage; consumes the UDP payload byte stream (MoldUDP64 header + message blocks).
- Extracts session, sequence number and message count, then splits the message blocks into individual ITCH messages using each block's 2-byte length prefix.
- Emits each message as a framed byte stream (first/last), tagged with its length and absolute sequence number, to the per-type ITCH decoders.
- No backpressure; one byte per cycle maximum.

---
 rtl/moldudp64_msg_splitter.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_moldudp64_msg_splitter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/moldudp64_msg_splitter.sv
// MoldUDP64 header parser and ITCH message splitter, one byte per cycle.
// Define MOLD_SEQ_GAP_CHECK_EN to track expected_seq and flag seq_gap.
module moldudp64_msg_splitter #(
   parameter int MAX_MSG_LEN = 64,
   parameter int LEN_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [7:0]       in_byte,
   input  logic             in_sop,
   input  logic             in_eop,
   output logic             msg_valid,
   output logic [7:0]       msg_byte,
   output logic             msg_first,
   output logic             msg_last,
   output logic [LEN_W-1:0] msg_len,
   output logic [63:0]      msg_seq,
   output logic [79:0]      session,
   output logic             hdr_done,
   output logic             heartbeat,
   output logic             end_session,
   output logic             err_trunc,
   output logic             err_len,
   output logic             err_extra,
   output logic             seq_gap,
   output logic [63:0]      expected_seq
);

   typedef enum logic [2:0] {
      IDLE, HDR, LEN_HI, LEN_LO, BODY, DRAIN
   } state_t;

   state_t      state, state_nx;
   logic [4:0]  hdr_idx, hdr_idx_nx;
   logic [79:0] sess_sh, sess_sh_nx;
   logic [63:0] seq_sh, seq_sh_nx;
   logic [7:0]  cnt_hi, cnt_hi_nx;
   logic [7:0]  len_hi, len_hi_nx;
   logic [15:0] count, count_nx;
   logic [15:0] len, len_nx;
   logic [15:0] rem, rem_nx;
   logic [15:0] msg_idx, msg_idx_nx;
   logic        arm, arm_nx;

   logic             msg_valid_nx, msg_first_nx, msg_last_nx;
   logic [7:0]       msg_byte_nx;
   logic [LEN_W-1:0] msg_len_nx;
   logic [63:0]      msg_seq_nx;
   logic [79:0]      session_nx;
   logic             hdr_done_nx, heartbeat_nx, end_session_nx;
   logic             err_trunc_nx, err_len_nx, err_extra_nx;

   logic [15:0] cnt_full, len_full;
   logic        len_bad, set_done;

   assign cnt_full = {cnt_hi, in_byte};
   assign len_full = {len_hi, in_byte};
   assign len_bad  = (len_full == 16'd0) ||
                     (len_full > 16'(MAX_MSG_LEN));
   assign set_done = (msg_idx + 16'd1) == count;

`ifdef MOLD_SEQ_GAP_CHECK_EN
   logic [63:0] exp_seq, exp_seq_nx;
   logic        known, known_nx;
   logic        seq_gap_nx;
   assign expected_seq = exp_seq;
`else
   assign seq_gap      = 1'b0;
   assign expected_seq = 64'd0;
`endif

   always_comb begin
      state_nx       = state;
      hdr_idx_nx     = hdr_idx;
      sess_sh_nx     = sess_sh;
      seq_sh_nx      = seq_sh;
      cnt_hi_nx      = cnt_hi;
      len_hi_nx      = len_hi;
      count_nx       = count;
      len_nx         = len;
      rem_nx         = rem;
      msg_idx_nx     = msg_idx;
      arm_nx         = arm;
      msg_valid_nx   = 1'b0;
      msg_first_nx   = 1'b0;
      msg_last_nx    = 1'b0;
      msg_byte_nx    = msg_byte;
      msg_len_nx     = msg_len;
      msg_seq_nx     = msg_seq;
      session_nx     = session;
      hdr_done_nx    = 1'b0;
      heartbeat_nx   = 1'b0;
      end_session_nx = 1'b0;
      err_trunc_nx   = 1'b0;
      err_len_nx     = 1'b0;
      err_extra_nx   = 1'b0;
`ifdef MOLD_SEQ_GAP_CHECK_EN
      exp_seq_nx     = exp_seq;
      known_nx       = known;
      seq_gap_nx     = 1'b0;
`endif
      if (in_valid) begin
         if (in_sop && in_eop) begin
            err_trunc_nx = 1'b1;
            state_nx     = IDLE;
         end else if (in_sop) begin
            // a new datagram always wins, even over a half-parsed one
            err_trunc_nx = (state != IDLE) && (state != DRAIN);
            state_nx     = HDR;
            hdr_idx_nx   = 5'd1;
            sess_sh_nx   = {sess_sh[71:0], in_byte};
            arm_nx       = 1'b0;
         end else begin
            case (state)
               HDR: begin
                  hdr_idx_nx = hdr_idx + 5'd1;
                  if (hdr_idx < 5'd10)
                     sess_sh_nx = {sess_sh[71:0], in_byte};
                  else if (hdr_idx < 5'd18)
                     seq_sh_nx = {seq_sh[55:0], in_byte};
                  else if (hdr_idx == 5'd18)
                     cnt_hi_nx = in_byte;
                  if (hdr_idx == 5'd19) begin
                     hdr_done_nx = 1'b1;
                     session_nx  = sess_sh;
                     count_nx    = cnt_full;
                     msg_idx_nx  = 16'd0;
                     arm_nx      = 1'b0;
`ifdef MOLD_SEQ_GAP_CHECK_EN
                     if (!known) begin
                        known_nx   = 1'b1;
                        exp_seq_nx = seq_sh;
                     end else if (seq_sh != exp_seq) begin
                        seq_gap_nx = 1'b1;
                     end
`endif
                     if (cnt_full == 16'h0000) begin
                        heartbeat_nx = 1'b1;
                        state_nx     = in_eop ? IDLE : DRAIN;
                     end else if (cnt_full == 16'hFFFF) begin
                        end_session_nx = 1'b1;
                        state_nx       = in_eop ? IDLE : DRAIN;
                     end else if (in_eop) begin
                        err_trunc_nx = 1'b1;
                        state_nx     = IDLE;
                     end else begin
                        state_nx = LEN_HI;
                     end
                  end else if (in_eop) begin
                     err_trunc_nx = 1'b1;
                     state_nx     = IDLE;
                  end
               end
               LEN_HI: begin
                  len_hi_nx = in_byte;
                  if (in_eop) begin
                     err_trunc_nx = 1'b1;
                     state_nx     = IDLE;
                  end else begin
                     state_nx = LEN_LO;
                  end
               end
               LEN_LO: begin
                  if (len_bad) begin
                     err_len_nx = 1'b1;
                     arm_nx     = 1'b0;
                     state_nx   = in_eop ? IDLE : DRAIN;
                  end else if (in_eop) begin
                     err_trunc_nx = 1'b1;
                     state_nx     = IDLE;
                  end else begin
                     len_nx     = len_full;
                     rem_nx     = len_full;
                     msg_len_nx = LEN_W'(len_full);
                     msg_seq_nx = seq_sh + {48'd0, msg_idx};
                     state_nx   = BODY;
                  end
               end
               BODY: begin
                  msg_valid_nx = 1'b1;
                  msg_byte_nx  = in_byte;
                  msg_first_nx = (rem == len);
                  msg_last_nx  = (rem == 16'd1);
                  if (rem == 16'd1) begin
                     msg_idx_nx = msg_idx + 16'd1;
`ifdef MOLD_SEQ_GAP_CHECK_EN
                     exp_seq_nx = msg_seq + 64'd1;
                     known_nx   = 1'b1;
`endif
                     if (set_done) begin
                        state_nx = in_eop ? IDLE : DRAIN;
                        arm_nx   = !in_eop;
                     end else if (in_eop) begin
                        err_trunc_nx = 1'b1;
                        state_nx     = IDLE;
                     end else begin
                        state_nx = LEN_HI;
                     end
                  end else begin
                     rem_nx = rem - 16'd1;
                     if (in_eop) begin
                        err_trunc_nx = 1'b1;
                        state_nx     = IDLE;
                     end
                  end
               end
               DRAIN: begin
                  if (arm) begin
                     err_extra_nx = 1'b1;
                     arm_nx       = 1'b0;
                  end
                  if (in_eop)
                     state_nx = IDLE;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         hdr_idx     <= '0;
         sess_sh     <= '0;
         seq_sh      <= '0;
         cnt_hi      <= '0;
         len_hi      <= '0;
         count       <= '0;
         len         <= '0;
         rem         <= '0;
         msg_idx     <= '0;
         arm         <= 1'b0;
         msg_valid   <= 1'b0;
         msg_byte    <= '0;
         msg_first   <= 1'b0;
         msg_last    <= 1'b0;
         msg_len     <= '0;
         msg_seq     <= '0;
         session     <= '0;
         hdr_done    <= 1'b0;
         heartbeat   <= 1'b0;
         end_session <= 1'b0;
         err_trunc   <= 1'b0;
         err_len     <= 1'b0;
         err_extra   <= 1'b0;
      end else begin
         state       <= state_nx;
         hdr_idx     <= hdr_idx_nx;
         sess_sh     <= sess_sh_nx;
         seq_sh      <= seq_sh_nx;
         cnt_hi      <= cnt_hi_nx;
         len_hi      <= len_hi_nx;
         count       <= count_nx;
         len         <= len_nx;
         rem         <= rem_nx;
         msg_idx     <= msg_idx_nx;
         arm         <= arm_nx;
         msg_valid   <= msg_valid_nx;
         msg_byte    <= msg_byte_nx;
         msg_first   <= msg_first_nx;
         msg_last    <= msg_last_nx;
         msg_len     <= msg_len_nx;
         msg_seq     <= msg_seq_nx;
         session     <= session_nx;
         hdr_done    <= hdr_done_nx;
         heartbeat   <= heartbeat_nx;
         end_session <= end_session_nx;
         err_trunc   <= err_trunc_nx;
         err_len     <= err_len_nx;
         err_extra   <= err_extra_nx;
      end
   end

`ifdef MOLD_SEQ_GAP_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         exp_seq <= '0;
         known   <= 1'b0;
         seq_gap <= 1'b0;
      end else begin
         exp_seq <= exp_seq_nx;
         known   <= known_nx;
         seq_gap <= seq_gap_nx;
      end
   end
`endif

endmodule

// File: tb/tb_moldudp64_msg_splitter.sv
// Bench for moldudp64_msg_splitter: datagram vector table plus scoreboard.
// Builds with or without MOLD_SEQ_GAP_CHECK_EN.
module tb_moldudp64_msg_splitter;

   localparam int MAXL = 64;

   logic        clk = 1'b0;
   logic        reset, in_valid, in_sop, in_eop;
   logic [7:0]  in_byte;
   logic        msg_valid, msg_first, msg_last;
   logic [7:0]  msg_byte;
   logic [15:0] msg_len;
   logic [63:0] msg_seq, expected_seq;
   logic [79:0] session;
   logic        hdr_done, heartbeat, end_session;
   logic        err_trunc, err_len, err_extra, seq_gap;

   moldudp64_msg_splitter #(.MAX_MSG_LEN(MAXL), .LEN_W(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid),
      .in_byte(in_byte), .in_sop(in_sop), .in_eop(in_eop),
      .msg_valid(msg_valid), .msg_byte(msg_byte),
      .msg_first(msg_first), .msg_last(msg_last),
      .msg_len(msg_len), .msg_seq(msg_seq), .session(session),
      .hdr_done(hdr_done), .heartbeat(heartbeat),
      .end_session(end_session), .err_trunc(err_trunc),
      .err_len(err_len), .err_extra(err_extra),
      .seq_gap(seq_gap), .expected_seq(expected_seq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  b;
      bit          sop, eop, body, first, last;
      logic [15:0] len;
      logic [63:0] seq;
   } tx_t;

   typedef struct {
      logic [7:0]  b;
      bit          first, last;
      logic [15:0] len;
      logic [63:0] seq;
      int          cyc;
   } exp_t;

   typedef struct {
      string       nm;
      logic [63:0] seq;
      logic [15:0] cnt;
      int          nmsg, l0, l1, extra, cut, hcut;
      bit          gaps;
      int          ehdr, ehb, ees, etr, elen, eex;
   } vec_t;

   tx_t  txq[$];
   exp_t expq[$];
   vec_t vt[13];

   int n_cmp = 0, n_bad = 0;
   int c_hdr, c_hb, c_es, c_tr, c_len, c_ex;
   int c_gap = 0;
   logic [63:0] gap_val = '0;
   logic [79:0] last_sess;

   task automatic chk(string nm, logic [79:0] act, logic [79:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic sample();
      exp_t e;
      if (hdr_done)    c_hdr++;
      if (heartbeat)   c_hb++;
      if (end_session) c_es++;
      if (err_trunc)   c_tr++;
      if (err_len)     c_len++;
      if (err_extra)   c_ex++;
      if (seq_gap) begin
         c_gap++;
         gap_val = expected_seq;
      end
      if (msg_valid) begin
         n_cmp++;
         if (expq.size() == 0) begin
            n_bad++;
            $display("FAIL msg_unexpected got %h want none", msg_byte);
         end else begin
            e = expq.pop_front();
            if (msg_byte !== e.b || msg_first !== e.first ||
                msg_last !== e.last || msg_len !== e.len ||
                msg_seq !== e.seq || cyc != e.cyc) begin
               n_bad++;
               $display("FAIL msg got b=%h f=%b l=%b len=%0d seq=%h cyc=%0d want b=%h f=%b l=%b len=%0d seq=%h cyc=%0d",
                  msg_byte, msg_first, msg_last, msg_len, msg_seq, cyc,
                  e.b, e.first, e.last, e.len, e.seq, e.cyc);
            end
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      sample();
   endtask

   task automatic clr();
      c_hdr = 0; c_hb = 0; c_es = 0;
      c_tr = 0; c_len = 0; c_ex = 0;
   endtask

   function automatic tx_t mk(logic [7:0] b, bit sop, bit body,
                              bit first, bit last, logic [15:0] len,
                              logic [63:0] seq);
      tx_t t;
      t.b = b; t.sop = sop; t.eop = 1'b0; t.body = body;
      t.first = first; t.last = last; t.len = len; t.seq = seq;
      return t;
   endfunction

   function automatic vec_t mkv(string nm, logic [63:0] seq,
      logic [15:0] cnt, int nmsg, int l0, int l1, int extra, int cut,
      int hcut, bit gaps, int ehdr, int ehb, int ees, int etr,
      int elen, int eex);
      vec_t v;
      v.nm = nm; v.seq = seq; v.cnt = cnt; v.nmsg = nmsg;
      v.l0 = l0; v.l1 = l1; v.extra = extra; v.cut = cut;
      v.hcut = hcut; v.gaps = gaps; v.ehdr = ehdr; v.ehb = ehb;
      v.ees = ees; v.etr = etr; v.elen = elen; v.eex = eex;
      return v;
   endfunction

   task automatic add_dgram(vec_t v, bit eop_last);
      logic [7:0]   hb[20];
      logic [79:0]  sess;
      logic [15:0]  l;
      logic [7:0]   b;
      int           nh, nb;
      sess = {v.seq[15:0] ^ 16'hA5A5, v.seq};
      for (int i = 0; i < 10; i++) hb[i] = sess[79-8*i -: 8];
      for (int i = 0; i < 8; i++) hb[10+i] = v.seq[63-8*i -: 8];
      hb[18] = v.cnt[15:8];
      hb[19] = v.cnt[7:0];
      nh = (v.hcut != 0) ? v.hcut : 20;
      for (int i = 0; i < nh; i++)
         txq.push_back(mk(hb[i], i == 0, 0, 0, 0, 0, 0));
      if (v.hcut == 0) begin
         last_sess = sess;
         for (int m = 0; m < v.nmsg; m++) begin
            l = 16'((m == 0) ? v.l0 : v.l1);
            txq.push_back(mk(l[15:8], 0, 0, 0, 0, 0, 0));
            txq.push_back(mk(l[7:0], 0, 0, 0, 0, 0, 0));
            if (l == 0 || l > MAXL) break;
            nb = (v.cut != 0 && m == v.nmsg - 1) ? v.cut : int'(l);
            for (int j = 0; j < nb; j++) begin
               b = (j != 0) ? 8'($urandom) :
                   ((m == 0) ? 8'h53 : 8'h41);
               txq.push_back(mk(b, 0, 1, j == 0, j == int'(l) - 1,
                                l, v.seq + 64'(m)));
            end
         end
         for (int k = 0; k < v.extra; k++)
            txq.push_back(mk(8'hE0 + 8'(k), 0, 0, 0, 0, 0, 0));
      end
      if (eop_last) txq[txq.size()-1].eop = 1'b1;
   endtask

   task automatic send_all(bit gaps);
      tx_t  t;
      exp_t e;
      while (txq.size() != 0) begin
         t = txq.pop_front();
         if (gaps && $urandom_range(0, 2) == 0) begin
            step();
            in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
         end
         step();
         in_valid = 1'b1; in_byte = t.b;
         in_sop = t.sop; in_eop = t.eop;
         if (t.body) begin
            e.b = t.b; e.first = t.first; e.last = t.last;
            e.len = t.len; e.seq = t.seq; e.cyc = cyc + 1;
            expq.push_back(e);
         end
      end
      step();
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      repeat (3) step();
   endtask

   task automatic chk_cnt(string nm, int hdr, int hb, int es,
                          int tr, int ln, int ex);
      chk({nm, ".hdr_done"},    80'(c_hdr), 80'(hdr));
      chk({nm, ".heartbeat"},   80'(c_hb),  80'(hb));
      chk({nm, ".end_session"}, 80'(c_es),  80'(es));
      chk({nm, ".err_trunc"},   80'(c_tr),  80'(tr));
      chk({nm, ".err_len"},     80'(c_len), 80'(ln));
      chk({nm, ".err_extra"},   80'(c_ex),  80'(ex));
      chk({nm, ".pending"},     80'(expq.size()), 80'd0);
      expq.delete();
   endtask

   task automatic run_vec(vec_t v);
      clr();
      add_dgram(v, 1'b1);
      send_all(v.gaps);
      chk_cnt(v.nm, v.ehdr, v.ehb, v.ees, v.etr, v.elen, v.eex);
      if (v.hcut == 0) chk({v.nm, ".session"}, session, last_sess);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
      repeat (3) step();
      reset = 1'b0;
   endtask

   initial begin
      vec_t v;
      reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0;
      in_eop = 1'b0; in_byte = 8'h00;
      clr();

      vt[0]  = mkv("two_msgs", 64'h10, 16'd2, 2, 12, 36, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      vt[1]  = mkv("heartbeat", 64'h20, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      vt[2]  = mkv("end_sess", 64'h21, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      vt[3]  = mkv("trunc_body", 64'h30, 16'd1, 1, 12, 0, 0, 5, 0, 0, 1, 0, 0, 1, 0, 0);
      vt[4]  = mkv("after_trunc", 64'h31, 16'd1, 1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      vt[5]  = mkv("len_zero", 64'h40, 16'd3, 1, 0, 0, 4, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      vt[6]  = mkv("len_256", 64'h41, 16'd1, 1, 256, 0, 4, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      vt[7]  = mkv("len_65", 64'h42, 16'd1, 1, 65, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0);
      vt[8]  = mkv("extra", 64'h50, 16'd1, 1, 10, 0, 3, 0, 0, 0, 1, 0, 0, 0, 0, 1);
      vt[9]  = mkv("gaps_max", 64'h60, 16'd2, 2, 5, 64, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
      vt[10] = mkv("seq_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 16'd2, 2, 1, 2, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
      vt[11] = mkv("hb_trail", 64'h70, 16'h0000, 0, 0, 0, 2, 0, 0, 0, 1, 1, 0, 0, 0, 0);
      vt[12] = mkv("hdr_cut", 64'h80, 16'd1, 0, 0, 0, 0, 0, 12, 0, 0, 0, 0, 1, 0, 0);

      repeat (3) step();
      chk("rst.msg_valid", 80'(msg_valid), 80'd0);
      chk("rst.msg_first", 80'(msg_first), 80'd0);
      chk("rst.msg_last", 80'(msg_last), 80'd0);
      chk("rst.msg_byte", 80'(msg_byte), 80'd0);
      chk("rst.msg_len", 80'(msg_len), 80'd0);
      chk("rst.msg_seq", 80'(msg_seq), 80'd0);
      chk("rst.session", session, 80'd0);
      chk("rst.flags", 80'({hdr_done, heartbeat, end_session,
          err_trunc, err_len, err_extra, seq_gap}), 80'd0);
      chk("rst.expected_seq", 80'(expected_seq), 80'd0);
      reset = 1'b0;
      step();

      for (int i = 0; i < 13; i++) run_vec(vt[i]);

      // reset while a message body is in flight
      clr();
      add_dgram(mkv("p", 64'h90, 16'd1, 1, 12, 0, 0, 6, 0, 0,
                    0, 0, 0, 0, 0, 0), 1'b0);
      send_all(1'b0);
      do_reset();
      repeat (2) step();
      chk_cnt("mid_reset", 1, 0, 0, 0, 0, 0);
      run_vec(mkv("post_reset", 64'h91, 16'd1, 1, 7, 0, 0, 0, 0, 0,
                  1, 0, 0, 0, 0, 0));

      // sop arriving mid-message restarts the parse
      clr();
      add_dgram(mkv("p", 64'hA0, 16'd2, 1, 12, 0, 0, 5, 0, 0,
                    0, 0, 0, 0, 0, 0), 1'b0);
      add_dgram(mkv("q", 64'hA8, 16'd1, 1, 9, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0), 1'b1);
      send_all(1'b0);
      chk_cnt("sop_restart", 2, 0, 0, 1, 0, 0);
      chk("sop_restart.session", session, last_sess);

      // single-byte datagram with sop and eop together
      clr();
      txq.push_back(mk(8'h00, 1, 0, 0, 0, 0, 0));
      txq[0].eop = 1'b1;
      send_all(1'b0);
      chk_cnt("sop_eop", 0, 0, 0, 1, 0, 0);
      run_vec(vt[0]);

`ifdef MOLD_SEQ_GAP_CHECK_EN
      do_reset();
      clr();
      c_gap = 0;
      add_dgram(mkv("g1", 64'd5, 16'd2, 2, 3, 4, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0), 1'b1);
      add_dgram(mkv("g2", 64'd9, 16'd1, 1, 2, 0, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0), 1'b1);
      send_all(1'b0);
      chk_cnt("seq_gap", 2, 0, 0, 0, 0, 0);
      chk("seq_gap.count", 80'(c_gap), 80'd1);
      chk("seq_gap.expected_at_gap", 80'(gap_val), 80'd7);
      chk("seq_gap.expected_final", 80'(expected_seq), 80'd10);
`else
      chk("seq_gap.tied", 80'(c_gap), 80'd0);
      chk("expected_seq.tied", 80'(expected_seq), 80'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               n_cmp, n_bad);
      $finish;
   end

endmodule
